vga_scan_gen: RTL

- Raster scan generator directly upstream of the digit glyph renderer.
- Produces pixel coordinates poX/poY, a pixel-rate enable, and the hsync/vsync/active-video strobes.
- The glyph renderer registers its pixel output one clock after it samples poX/poY. This block therefore also emits copies of the sync/active strobes delayed by PIPE clocks, so they align with that pixel output at the VGA pins.

---
 rtl/vga_pkg.sv | 38 +++
 rtl/sync_delay.sv | 28 ++
 rtl/vga_scan_gen.sv | 119 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants and coordinate types used by the scan generator
// and the glyph renderer.
package vga_pkg;

  localparam int unsigned COORD_W = 11;
  // Compare width is one bit wider than a coordinate so sums like lo+len cannot overflow.
  localparam int unsigned CMP_W   = 12;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  localparam int unsigned DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } strobe_t;

  function automatic logic below(coord_t val, int unsigned lim);
    return {1'b0, val} < CMP_W'(lim);
  endfunction

  // True when lo <= val < lo+len.
  function automatic logic in_window(coord_t val, int unsigned lo, int unsigned len);
    return !below(val, lo) && below(val, lo + len);
  endfunction

endpackage

// File: rtl/sync_delay.sv
// PIPE-deep shift register with a loadable reset value; advances every clock.
module sync_delay #(
  parameter int unsigned W    = 1,
  parameter int unsigned PIPE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_val,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  localparam int unsigned SR_W = PIPE * W;

  logic [SR_W-1:0] sr_q;

  // Newest sample enters at the bottom; the oldest falls off the top.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_q <= {PIPE{rst_val}};
    end else begin
      sr_q <= SR_W'({sr_q, din});
    end
  end

  assign dout = sr_q[SR_W-1 -: W];

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel-rate enable, coordinates, sync/active strobes, and
// copies of the strobes delayed to line up with the glyph renderer's registered pixel.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int unsigned DIV      = 4,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter logic        SYNC_POL = 1'b0,
  parameter int unsigned PIPE     = 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               pix_en,
  output logic [COORD_W-1:0] poX,
  output logic [COORD_W-1:0] poY,
  output logic               active,
  output logic               hsync,
  output logic               vsync,
  output logic               frame_start,
  output logic               active_d,
  output logic               hsync_d,
  output logic               vsync_d
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned DIV_W = 4;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam coord_t H_LAST = COORD_W'(H_TOTAL - 1);
  localparam coord_t V_LAST = COORD_W'(V_TOTAL - 1);
  localparam coord_t ONE    = COORD_W'(1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             pix_en_q, pix_en_d;
  coord_t           h_cnt_q, h_cnt_d;
  coord_t           v_cnt_q, v_cnt_d;
  logic             h_wrap, v_wrap;
  logic             frame_start_q, frame_start_d;
  strobe_t          strb_q, strb_d;
  strobe_t          strb_idle;
  strobe_t          strb_dly;

  assign strb_idle = {1'b0, ~SYNC_POL, ~SYNC_POL};

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
    // Registered enable is high for the clk in which div_cnt==DIV-1 is held.
    pix_en_d  = (div_cnt_d == DIV_LAST);

    h_wrap = pix_en_q && (h_cnt_q == H_LAST);
    v_wrap = h_wrap && (v_cnt_q == V_LAST);

    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en_q) begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + ONE;
    end
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + ONE;
    end

    frame_start_d = v_wrap;

    // Decode the next-state counters so strobes are exact for the coordinates they
    // are registered alongside.
    strb_d.active = below(h_cnt_d, H_ACTIVE) && below(v_cnt_d, V_ACTIVE);
    strb_d.hsync  = in_window(h_cnt_d, H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
    strb_d.vsync  = in_window(v_cnt_d, V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt_q     <= '0;
      pix_en_q      <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
      strb_q        <= strb_idle;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_en_q      <= pix_en_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
      strb_q        <= strb_d;
    end
  end

  sync_delay #(
    .W    ($bits(strobe_t)),
    .PIPE (PIPE)
  ) u_sync_delay (
    .clk     (clk),
    .rst     (rst),
    .rst_val (strb_idle),
    .din     (strb_q),
    .dout    (strb_dly)
  );

  assign pix_en      = pix_en_q;
  assign poX         = h_cnt_q;
  assign poY         = v_cnt_q;
  assign active      = strb_q.active;
  assign hsync       = strb_q.hsync;
  assign vsync       = strb_q.vsync;
  assign frame_start = frame_start_q;
  assign active_d    = strb_dly.active;
  assign hsync_d     = strb_dly.hsync;
  assign vsync_d     = strb_dly.vsync;

endmodule
